// File: rtl/mcu_spi_slave_pkg.sv
// Shared definitions for the MCU SPI slave front-end.
// - SPI_MODE0    : {CPOL, CPHA} of the supported SPI mode.
// - CMD_BYTE_IDX : byte_cnt value that identifies the command byte of a transfer.
// - ssel_state_e : transfer state (select idle / select active).
// - sample_on_rise(): for a given {CPOL, CPHA}, whether MOSI is sampled on the rising SCK edge.
package mcu_spi_slave_pkg;

    localparam logic [1:0] SPI_MODE0    = 2'b00;
    localparam int         CMD_BYTE_IDX = 1;

    typedef enum logic {
        SSEL_IDLE   = 1'b0,
        SSEL_ACTIVE = 1'b1
    } ssel_state_e;

    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
    function automatic logic sample_on_rise(input logic [1:0] mode);
        return mode[1] == mode[0];
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage synchroniser for one asynchronous SPI pin, with edge detection.
// Ports:
// - clk, rst_n : system clock, asynchronous active-low reset
// - i_async    : asynchronous pin input
// - o_sync     : synchronised level (last synchroniser stage)
// - o_rise     : 1-cycle pulse on a rising edge of o_sync
// - o_fall     : 1-cycle pulse on a falling edge of o_sync
module spi_in_sync #(
    parameter int   STAGES  = 3,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;
    // Fills with ones after reset; its top bit says both o_sync and the
    // history FF hold real pin samples rather than reset values, so no edge
    // is reported from the reset value to the first real sample.
    logic [STAGES:0]   r_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_hist <= RST_VAL;
            r_vld  <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_hist <= r_sync[STAGES-1];
            r_vld  <= {r_vld[STAGES-1:0], 1'b1};
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_vld[STAGES] &  r_sync[STAGES-1] & ~r_hist;
    assign o_fall = r_vld[STAGES] & ~r_sync[STAGES-1] &  r_hist;

endmodule

// File: rtl/mcu_spi_slave.sv
// SPI mode-0 slave front-end between MCU SPI pins and the command decoder.
// Oversamples SCK/MOSI/SSEL in the clk domain, deserialises MSB-first bytes and
// strobes the first byte of a transfer as a command, all later bytes as parameters.
// The decoder's response byte (input_data) is serialised onto MISO.
// Ports:
// - clk, rst_n              : system clock, asynchronous active-low reset
// - SCK, MOSI, SSEL         : asynchronous SPI pins from the MCU (SSEL active-low)
// - MISO                    : registered SPI data to the MCU
// - input_data              : response byte shifted out on the next byte
// - cmd_ready / param_ready : 1-cycle strobes for a completed command / parameter byte
// - cmd_data / param_data   : last command / parameter byte, held until replaced
// - byte_cnt                : completed bytes in the current transfer (saturating)
// - bit_cnt                 : bits received in the current byte
module mcu_spi_slave
    import mcu_spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int BYTE_CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SCK,
    input  logic                  MOSI,
    input  logic                  SSEL,
    output logic                  MISO,
    input  logic [7:0]            input_data,
    output logic                  cmd_ready,
    output logic                  param_ready,
    output logic [7:0]            cmd_data,
    output logic [7:0]            param_data,
    output logic [BYTE_CNT_W-1:0] byte_cnt,
    output logic [2:0]            bit_cnt
);

    localparam logic SAMPLE_RISE = sample_on_rise(SPI_MODE0);

    logic w_sck_sync_unused, w_sck_rise, w_sck_fall;
    logic w_mosi_sync, w_mosi_rise_unused, w_mosi_fall_unused;
    logic w_ssel_sync, w_ssel_rise_unused, w_ssel_fall;
    logic w_sample, w_shift;
    logic [7:0]            w_rx_next;
    logic [BYTE_CNT_W-1:0] w_byte_cnt_inc;

    ssel_state_e           r_state;
    logic [7:0]            r_rx;
    logic [7:0]            r_tx;
    logic                  r_miso;
    logic [2:0]            r_bit_cnt;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic                  r_byte_done;
    logic [7:0]            r_done_byte;
    logic                  r_done_cmd;
    logic                  r_cmd_ready;
    logic                  r_param_ready;
    logic [7:0]            r_cmd_data;
    logic [7:0]            r_param_data;

    function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] v);
        return (&v) ? v : v + BYTE_CNT_W'(1);
    endfunction

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(SCK),
        .o_sync (w_sck_sync_unused),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(MOSI),
        .o_sync (w_mosi_sync),
        .o_rise (w_mosi_rise_unused),
        .o_fall (w_mosi_fall_unused)
    );

    // SSEL resets to "deasserted" so a select held low through reset is not
    // mistaken for a new transfer.
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ssel_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(SSEL),
        .o_sync (w_ssel_sync),
        .o_rise (w_ssel_rise_unused),
        .o_fall (w_ssel_fall)
    );

    assign w_sample       = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
    assign w_shift        = SAMPLE_RISE ? w_sck_fall : w_sck_rise;
    assign w_rx_next      = {r_rx[6:0], w_mosi_sync};
    assign w_byte_cnt_inc = sat_inc(r_byte_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= SSEL_IDLE;
            r_rx          <= '0;
            r_tx          <= '0;
            r_miso        <= 1'b1;
            r_bit_cnt     <= '0;
            r_byte_cnt    <= '0;
            r_byte_done   <= 1'b0;
            r_done_byte   <= '0;
            r_done_cmd    <= 1'b0;
            r_cmd_ready   <= 1'b0;
            r_param_ready <= 1'b0;
            r_cmd_data    <= 8'h00;
            r_param_data  <= '0;
        end else begin
            r_byte_done   <= 1'b0;
            r_cmd_ready   <= 1'b0;
            r_param_ready <= 1'b0;

            // Strobe stage: one cycle after a byte completes. Kept outside the
            // SSEL handling so a completed byte is delivered even if the select
            // rises right behind it.
            if (r_byte_done) begin
                if (r_done_cmd) begin
                    r_cmd_data  <= r_done_byte;
                    r_cmd_ready <= 1'b1;
                end else begin
                    r_param_data  <= r_done_byte;
                    r_param_ready <= 1'b1;
                end
            end

            // Select level has priority over any SCK edge in the same cycle;
            // a partial byte is simply dropped.
            if (w_ssel_sync) begin
                r_state    <= SSEL_IDLE;
                r_rx       <= '0;
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
            end else if (r_state == SSEL_IDLE) begin
                if (w_ssel_fall) begin
                    r_state <= SSEL_ACTIVE;
                    r_tx    <= input_data;
                    r_miso  <= input_data[7];
                end
            end else begin
                if (w_sample) begin
                    r_rx      <= w_rx_next;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_byte_done <= 1'b1;
                        r_done_byte <= w_rx_next;
                        r_done_cmd  <= (w_byte_cnt_inc == BYTE_CNT_W'(CMD_BYTE_IDX));
                        r_byte_cnt  <= w_byte_cnt_inc;
                    end
                end
                // At a byte boundary the next response byte is taken from the
                // decoder; by then its reply to the last strobe is in place.
                if (w_shift) begin
                    if (r_bit_cnt == 3'd0) begin
                        r_tx   <= input_data;
                        r_miso <= input_data[7];
                    end else begin
                        r_tx   <= {r_tx[6:0], 1'b0};
                        r_miso <= r_tx[6];
                    end
                end
            end
        end
    end

    assign MISO        = r_miso;
    assign cmd_ready   = r_cmd_ready;
    assign param_ready = r_param_ready;
    assign cmd_data    = r_cmd_data;
    assign param_data  = r_param_data;
    assign byte_cnt    = r_byte_cnt;
    assign bit_cnt     = r_bit_cnt;

endmodule

// File: tb/tb_mcu_spi_slave.sv
module tb_mcu_spi_slave;

    localparam int SYNC = 3;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SCK, MOSI, SSEL;
    logic [7:0]  input_data = 8'h00;
    logic        MISO, cmd_ready, param_ready;
    logic [7:0]  cmd_data, param_data;
    logic [31:0] byte_cnt;
    logic [2:0]  bit_cnt;

    typedef struct {
        bit         is_cmd;
        logic [7:0] data;
        int         cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tx_bytes[$];
    logic [7:0] rx_got[$];
    logic [7:0] idle_val = 8'h00;
    logic [7:0] m_cmd = 8'h00;
    logic [7:0] m_param = 8'h00;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_cmd_seen = 0;
    int         n_param_seen = 0;

    mcu_spi_slave #(.SYNC_STAGES(SYNC), .BYTE_CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SCK        (SCK),
        .MOSI       (MOSI),
        .SSEL       (SSEL),
        .MISO       (MISO),
        .input_data (input_data),
        .cmd_ready  (cmd_ready),
        .param_ready(param_ready),
        .cmd_data   (cmd_data),
        .param_data (param_data),
        .byte_cnt   (byte_cnt),
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Decoder stand-in: answers each strobe one cycle later with byte ^ 0x55;
    // while the select is high it presents idle_val as the first response.
    always @(posedge clk) begin
        #1;
        if (cmd_ready) input_data = cmd_data ^ 8'h55;
        else if (param_ready) input_data = param_data ^ 8'h55;
        else if (SSEL) input_data = idle_val;
    end

    // Per-cycle compare against the model's expected strobe queue and held data.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("rst_param_ready", 64'(param_ready), 64'd0);
            chk("rst_cmd_data", 64'(cmd_data), 64'd0);
            chk("rst_param_data", 64'(param_data), 64'd0);
            chk("rst_byte_cnt", 64'(byte_cnt), 64'd0);
            chk("rst_bit_cnt", 64'(bit_cnt), 64'd0);
            chk("rst_miso", 64'(MISO), 64'd1);
            m_cmd = 8'h00;
            m_param = 8'h00;
        end else begin
            chk("strobe_exclusive", 64'(cmd_ready & param_ready), 64'd0);
            if (cmd_ready || param_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 64'({cmd_ready, param_ready}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", 64'({cmd_ready, param_ready}), e.is_cmd ? 64'd2 : 64'd1);
                    chk("strobe_byte_cnt", 64'(byte_cnt), 64'(e.cnt));
                    if (e.is_cmd) begin
                        m_cmd = e.data;
                        n_cmd_seen++;
                    end else begin
                        m_param = e.data;
                        n_param_seen++;
                    end
                    chk("cmd_data", 64'(cmd_data), 64'(m_cmd));
                    chk("param_data", 64'(param_data), 64'(m_param));
                end
            end else begin
                chk("cmd_data_hold", 64'(cmd_data), 64'(m_cmd));
                chk("param_data_hold", 64'(param_data), 64'(m_param));
            end
        end
    end

    // MCU-side master. cut_bits < 0: complete transfer. Otherwise stop after
    // cut_bits bits and either raise SSEL (cut_rst=0) or pulse rst_n (cut_rst=1).
    task automatic xfer(input int half, input int cut_bits, input bit cut_rst);
        logic [7:0] exp_resp, b, got;
        exp_t       e;
        int         nbits;
        bit         stop;
        nbits = 0;
        stop = 0;
        rx_got.delete();
        idle_val = 8'($urandom);
        clks(4);
        exp_resp = idle_val;
        SSEL = 1'b0;
        for (int i = 0; i < tx_bytes.size() && !stop; i++) begin
            b = tx_bytes[i];
            got = '0;
            for (int k = 7; k >= 0; k--) begin
                MOSI = b[k];
                clks(half);
                chk("bit_cnt", 64'(bit_cnt), 64'(7 - k));
                chk("byte_cnt", 64'(byte_cnt), 64'(i));
                SCK = 1'b1;
                got[k] = MISO;
                nbits++;
                if (k == 0) begin
                    e.is_cmd = (i == 0);
                    e.data = b;
                    e.cnt = i + 1;
                    exp_q.push_back(e);
                end
                clks(half);
                SCK = 1'b0;
                if (nbits == cut_bits) begin
                    stop = 1;
                    break;
                end
            end
            if (!stop) begin
                chk("miso_byte", 64'(got), 64'(exp_resp));
                rx_got.push_back(got);
                exp_resp = b ^ 8'h55;
            end
        end
        clks(half);
        if (stop && cut_rst) begin
            #2 rst_n = 1'b0;
            #1;
            chk("async_rst_cmd_data", 64'(cmd_data), 64'd0);
            chk("async_rst_byte_cnt", 64'(byte_cnt), 64'd0);
            chk("async_rst_bit_cnt", 64'(bit_cnt), 64'd0);
            chk("async_rst_miso", 64'(MISO), 64'd1);
            clks(3);
            rst_n = 1'b1;
            // SSEL still low: clock a full byte that must be ignored.
            for (int j = 0; j < 8; j++) begin
                MOSI = 1'($urandom);
                clks(half);
                SCK = 1'b1;
                clks(half);
                SCK = 1'b0;
            end
            clks(SYNC + 6);
            chk("post_rst_bit_cnt", 64'(bit_cnt), 64'd0);
            chk("post_rst_byte_cnt", 64'(byte_cnt), 64'd0);
            SSEL = 1'b1;
            clks(SYNC + 6);
        end else begin
            if (stop) begin
                chk("abort_bit_cnt", 64'(bit_cnt), 64'(cut_bits % 8));
                chk("abort_byte_cnt", 64'(byte_cnt), 64'(cut_bits / 8));
            end
            SSEL = 1'b1;
            clks(SYNC + 6);
            chk("strobes_delivered", 64'(exp_q.size()), 64'd0);
            chk("idle_bit_cnt", 64'(bit_cnt), 64'd0);
            chk("idle_byte_cnt", 64'(byte_cnt), 64'd0);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, p0;
        rst_n = 1'b0;
        SCK = 1'b0;
        MOSI = 1'b0;
        SSEL = 1'b1;
        clks(5);
        rst_n = 1'b1;
        clks(SYNC + 4);

        // T1: command only
        c0 = n_cmd_seen; p0 = n_param_seen;
        tx_bytes = '{8'h3A};
        xfer(HALF, -1, 0);
        chk("t1_cmd_data", 64'(cmd_data), 64'h3A);
        chk("t1_cmd_count", 64'(n_cmd_seen - c0), 64'd1);
        chk("t1_param_count", 64'(n_param_seen - p0), 64'd0);

        // T2: command plus three parameters
        c0 = n_cmd_seen; p0 = n_param_seen;
        tx_bytes = '{8'h10, 8'hC0, 8'h00, 8'h00};
        xfer(HALF, -1, 0);
        chk("t2_cmd_data", 64'(cmd_data), 64'h10);
        chk("t2_param_data", 64'(param_data), 64'h00);
        chk("t2_cmd_count", 64'(n_cmd_seen - c0), 64'd1);
        chk("t2_param_count", 64'(n_param_seen - p0), 64'd3);

        // T3: response to command 0xF0 comes back as 0xA5 in byte 2
        tx_bytes = '{8'hF0, 8'h12};
        xfer(HALF, -1, 0);
        chk("t3_miso_byte2", 64'(rx_got[1]), 64'hA5);

        // T4: abort after 5 bits of byte 2, then a fresh command
        c0 = n_cmd_seen; p0 = n_param_seen;
        tx_bytes = '{8'h77, 8'h5B};
        xfer(HALF, 13, 0);
        chk("t4_param_count", 64'(n_param_seen - p0), 64'd0);
        chk("t4_cmd_count", 64'(n_cmd_seen - c0), 64'd1);
        tx_bytes = '{8'h9C};
        xfer(HALF, -1, 0);
        chk("t4_next_cmd", 64'(cmd_data), 64'h9C);

        // T5: reset at bit 4 of parameter 0xD2
        c0 = n_cmd_seen; p0 = n_param_seen;
        tx_bytes = '{8'h41, 8'hD2};
        xfer(HALF, 12, 1);
        chk("t5_param_count", 64'(n_param_seen - p0), 64'd0);
        chk("t5_cmd_data_cleared", 64'(cmd_data), 64'h00);
        tx_bytes = '{8'h66, 8'h01};
        xfer(HALF, -1, 0);
        chk("t5_cmd_after", 64'(cmd_data), 64'h66);
        chk("t5_param_after", 64'(param_data), 64'h01);

        // T6: SCK activity with SSEL high is ignored
        for (int j = 0; j < 3; j++) begin
            MOSI = 1'($urandom);
            clks(SYNC + 4);
            SCK = 1'b1;
            clks(SYNC + 4);
            SCK = 1'b0;
        end
        clks(SYNC + 6);
        chk("t6_glitch_bit_cnt", 64'(bit_cnt), 64'd0);
        chk("t6_glitch_byte_cnt", 64'(byte_cnt), 64'd0);

        // T6: minimum SCK timing, 256 random bytes
        tx_bytes.delete();
        for (int j = 0; j < 256; j++) tx_bytes.push_back(8'($urandom));
        xfer(SYNC + 4, -1, 0);
        chk("t6_last_param", 64'(param_data), 64'(tx_bytes[255]));

        // Random short transfers at random legal speeds
        for (int t = 0; t < 6; t++) begin
            tx_bytes.delete();
            for (int j = 0; j < int'($urandom_range(1, 6)); j++) tx_bytes.push_back(8'($urandom));
            xfer(int'($urandom_range(SYNC + 4, 12)), -1, 0);
        end

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
